// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants for a 100 MHz system clock.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    // 10 ms qualification window and 1 s long-press threshold at 100 MHz
    localparam int DEFAULT_STABLE_CYCLES = 32'd1_000_000;
    localparam int DEFAULT_LONG_CYCLES   = 32'd100_000_000;

endpackage

// File: rtl/sync_ff.sv
// N-flop synchroniser for one asynchronous pin; asynchronous active-high
// reset clears every stage to 0.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] r_sync;

    // shift the raw pin through N flops; stage 0 is the metastability catcher
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], d};
        end
    end

    assign q = r_sync[N-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button pin into a clean pressed level.
// Optional long-press detector enabled by defining DEBOUNCE_LONGPRESS_EN.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic long_press
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (w_s)
    );

    // state and qualification counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // next-state logic: a mismatch on s always wins over the terminal count
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // decoded purely from the state flops so the level cannot glitch
    assign out = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int              LP_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_CYCLES);

    logic [LP_W-1:0] r_lp_cnt;

    // hold-time counter: runs in PRESSED, freezes in RELEASE_WAIT, clears on IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lp_cnt <= '0;
        end else if (w_state_nxt == IDLE) begin
            r_lp_cnt <= '0;
        end else if ((r_state == PRESSED) && (r_lp_cnt != LP_MAX)) begin
            r_lp_cnt <= r_lp_cnt + 1'b1;
        end else begin
            r_lp_cnt <= r_lp_cnt;
        end
    end

    assign long_press = (r_lp_cnt == LP_MAX);
`else
    // feature not built; the threshold is only referenced to keep it visible
    assign long_press = 1'b0 & (LONG_CYCLES > 0);
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer with a run-length model
// of the debounce rules; long_press expectations follow DEBOUNCE_LONGPRESS_EN.
module tb_button_debouncer;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int LONG   = 10;
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic r_in  = 1'b0;
    logic out_s;
    logic lp_s;

    int checks   = 0;
    int failures = 0;

    // reference model: input delay line, run of mismatching samples, hold time
    bit m_pipe [SYNC];
    int m_run;
    int m_lp;
    bit m_out;
    bit m_lpx;

    button_debouncer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (r_in),
        .out        (out_s),
        .long_press (lp_s)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int k = 0; k < SYNC; k++) m_pipe[k] = 1'b0;
        m_run = 0;
        m_lp  = 0;
        m_out = 1'b0;
        m_lpx = 1'b0;
    endtask

    // out flips once the FSM has seen STABLE+1 consecutive samples differing from it
    task automatic model_edge(input bit v);
        bit seen;
        seen = m_pipe[SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = v;
        if (m_out && m_run == 0 && m_lp < LONG) m_lp = m_lp + 1;
        if (seen != m_out) begin
            m_run = m_run + 1;
            if (m_run == STABLE + 1) begin
                m_out = ~m_out;
                m_run = 0;
                if (!m_out) m_lp = 0;
            end
        end else begin
            m_run = 0;
        end
        m_lpx = LP_EN && (m_lp == LONG);
    endtask

    // drive at the falling edge, let one rising edge happen, return at the next falling edge
    task automatic tick(input bit v);
        r_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_s, lp_s} !== 2'b00) begin
            failures++;
            $display("FAIL reset_state: out/long_press=%b expected=00", {out_s, lp_s});
        end
        model_clear();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0);
    endtask

    task automatic test_clean_press();
        int rise_at;
        int lp_at;
        rise_at = 0;
        lp_at   = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1'b1);
            checks++;
            if ({out_s, lp_s} !== {m_out, m_lpx}) begin
                failures++;
                $display("FAIL clean_press cyc%0d: out/lp=%b expected=%b", i, {out_s, lp_s}, {m_out, m_lpx});
            end
            if (out_s === 1'b1 && rise_at == 0) rise_at = i;
            if (lp_s === 1'b1 && lp_at == 0) lp_at = i;
        end
        checks++;
        if (rise_at != SYNC + STABLE + 1) begin
            failures++;
            $display("FAIL press_latency: rose at edge %0d expected %0d", rise_at, SYNC + STABLE + 1);
        end
        checks++;
        if (lp_at != (LP_EN ? SYNC + STABLE + 1 + LONG : 0)) begin
            failures++;
            $display("FAIL long_press_latency: at edge %0d expected %0d", lp_at, LP_EN ? SYNC + STABLE + 1 + LONG : 0);
        end
    endtask

    task automatic test_bounce();
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int rise_at;
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0);
        rise_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(i <= 6 ? pat[i-1] : 1'b1);
            checks++;
            if ({out_s, lp_s} !== {m_out, m_lpx}) begin
                failures++;
                $display("FAIL bounce cyc%0d: out/lp=%b expected=%b", i, {out_s, lp_s}, {m_out, m_lpx});
            end
            if (out_s === 1'b1 && rise_at == 0) rise_at = i;
        end
        checks++;
        if (rise_at != 6 + SYNC + STABLE) begin
            failures++;
            $display("FAIL bounce_latency: rose at edge %0d expected %0d", rise_at, 6 + SYNC + STABLE);
        end
    endtask

    task automatic test_short_glitch();
        bit seen_high;
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0);
        seen_high = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick(i <= 3 ? 1'b1 : 1'b0);
            if (out_s !== 1'b0) seen_high = 1'b1;
        end
        checks++;
        if (seen_high !== 1'b0) begin
            failures++;
            $display("FAIL short_glitch: out went high=%b expected=0", seen_high);
        end
    endtask

    task automatic test_release_rebounce();
        int fall_at;
        int lpfall_at;
        for (int i = 1; i <= 25; i++) tick(1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick(i <= 2 ? 1'b0 : 1'b1);
            checks++;
            if ({out_s, lp_s} !== {1'b1, LP_EN}) begin
                failures++;
                $display("FAIL rebounce_hold cyc%0d: out/lp=%b expected=%b", i, {out_s, lp_s}, {1'b1, LP_EN});
            end
        end
        fall_at   = 0;
        lpfall_at = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(1'b0);
            checks++;
            if ({out_s, lp_s} !== {m_out, m_lpx}) begin
                failures++;
                $display("FAIL release cyc%0d: out/lp=%b expected=%b", i, {out_s, lp_s}, {m_out, m_lpx});
            end
            if (out_s === 1'b0 && fall_at == 0) fall_at = i;
            if (lp_s === 1'b0 && lpfall_at == 0) lpfall_at = i;
        end
        checks++;
        if (fall_at != SYNC + STABLE + 1) begin
            failures++;
            $display("FAIL release_latency: fell at edge %0d expected %0d", fall_at, SYNC + STABLE + 1);
        end
        checks++;
        if (lpfall_at != (LP_EN ? SYNC + STABLE + 1 : 1)) begin
            failures++;
            $display("FAIL long_press_clear: at edge %0d expected %0d", lpfall_at, LP_EN ? SYNC + STABLE + 1 : 1);
        end
    endtask

    task automatic test_reset_mid();
        int rise_at;
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0);
        for (int i = 0; i < SYNC + 3; i++) tick(1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if ({out_s, lp_s} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_wait: out/lp=%b expected=00", {out_s, lp_s});
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        rise_at = 0;
        for (int i = 1; i <= 25; i++) begin
            tick(1'b1);
            if (out_s === 1'b1 && rise_at == 0) rise_at = i;
        end
        checks++;
        if (rise_at != SYNC + STABLE + 1) begin
            failures++;
            $display("FAIL reset_mid_latency: rose at edge %0d expected %0d", rise_at, SYNC + STABLE + 1);
        end
        // reset while pressed must drop out without waiting for a clock edge
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_s, lp_s} !== 2'b00) begin
            failures++;
            $display("FAIL reset_async_pressed: out/lp=%b expected=00", {out_s, lp_s});
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_hold_50();
        do_reset();
        for (int i = 1; i <= 50; i++) begin
            tick(1'b1);
            checks++;
            if ({out_s, lp_s} !== {m_out, m_lpx}) begin
                failures++;
                $display("FAIL hold50 cyc%0d: out/lp=%b expected=%b", i, {out_s, lp_s}, {m_out, m_lpx});
            end
        end
    endtask

    task automatic test_random();
        int  run_left;
        bit  v;
        bit  prev_out;
        int  last_change;
        do_reset();
        run_left    = 0;
        v           = 1'b0;
        prev_out    = 1'b0;
        last_change = -100;
        for (int i = 0; i < 1500; i++) begin
            if (run_left == 0) begin
                v        = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                prev_out    = 1'b0;
                last_change = -100;
            end
            tick(v);
            checks++;
            if ({out_s, lp_s} !== {m_out, m_lpx}) begin
                failures++;
                $display("FAIL random cyc%0d: out/lp=%b expected=%b", i, {out_s, lp_s}, {m_out, m_lpx});
            end
            if (out_s !== prev_out) begin
                checks++;
                if (i - last_change < STABLE + 1) begin
                    failures++;
                    $display("FAIL out_rate: gap %0d cycles expected >= %0d", i - last_change, STABLE + 1);
                end
                last_change = i;
                prev_out    = out_s;
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_press();
        test_release_rebounce();
        test_bounce();
        test_short_glitch();
        test_reset_mid();
        test_hold_50();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
